// File: rtl/lm80c_ce_pkg.sv
`default_nettype none
// ============================================================================
// lm80c_ce_pkg : shared constants and channel config type for the CE generator
// Revision 1.0
// ============================================================================
package lm80c_ce_pkg;

    localparam int MAX_CH = 8;
    localparam int CH_W   = 3;
    localparam int CFG_W  = 8;

    localparam logic [CFG_W-1:0] DIV_PIXEL = 8'd2;
    localparam logic [CFG_W-1:0] DIV_VDP   = 8'd4;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] phase;
    } ce_cfg_t;

endpackage
`default_nettype wire

// File: rtl/lm80c_ce_chan.sv
`default_nettype none
// ============================================================================
// lm80c_ce_chan : one clock-enable channel (counter, active/shadow pair, CE reg)
// Revision 1.0
// ============================================================================
module lm80c_ce_chan
    import lm80c_ce_pkg::*;
#(
    parameter int               DIV_W     = CFG_W,
    parameter logic [DIV_W-1:0] DEF_DIV   = DIV_PIXEL,
    parameter logic [DIV_W-1:0] DEF_PHASE = '0
) (
    input  logic             clk_vdp,
    input  logic             reset,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic [DIV_W-1:0] wr_phase_i,
    input  logic             resync_i,
    output logic             ce_o,
    output logic             pending_o
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] d,
                                                     input logic [DIV_W-1:0] p);
        if ((d != '0) && (p >= d)) begin
            return d - ONE;
        end
        return p;
    endfunction

    localparam logic [DIV_W-1:0] DEF_PHASE_CL = clamp_phase(DEF_DIV, DEF_PHASE);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d;
    logic [DIV_W-1:0] sphase_q, sphase_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             ce_q, ce_d;

    logic [DIV_W-1:0] ld_div;
    logic [DIV_W-1:0] ld_phase;
    logic             ld_avail;
    logic             off;
    logic             wrap;

    always_comb begin
        // A write in the same cycle as a load point is taken directly
        ld_div   = wr_i ? wr_div_i   : sdiv_q;
        ld_phase = wr_i ? wr_phase_i : sphase_q;
        ld_avail = wr_i | pend_q;
        off      = (div_q == '0);
        wrap     = !off && (cnt_q == (div_q - ONE));

        div_d    = div_q;
        phase_d  = phase_q;
        sdiv_d   = ld_div;
        sphase_d = ld_phase;
        pend_d   = ld_avail;
        cnt_d    = (off || wrap) ? '0 : (cnt_q + ONE);
        ce_d     = !resync_i && !off && (cnt_q == phase_q);

        if (resync_i || (ld_avail && (off || wrap))) begin
            cnt_d  = '0;
            pend_d = 1'b0;
            if (ld_avail) begin
                div_d   = ld_div;
                phase_d = clamp_phase(ld_div, ld_phase);
            end
        end
    end

    always_ff @(posedge clk_vdp or posedge reset) begin
        if (reset) begin
            div_q    <= DEF_DIV;
            phase_q  <= DEF_PHASE_CL;
            sdiv_q   <= DEF_DIV;
            sphase_q <= DEF_PHASE;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            ce_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            phase_q  <= phase_d;
            sdiv_q   <= sdiv_d;
            sphase_q <= sphase_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            ce_q     <= ce_d;
        end
    end

    assign ce_o      = ce_q;
    assign pending_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/lm80c_ce_gen.sv
`default_nettype none
// ============================================================================
// lm80c_ce_gen : multi-channel programmable clock-enable generator (VDP domain)
// Revision 1.0
// ============================================================================
module lm80c_ce_gen
    import lm80c_ce_pkg::*;
#(
    parameter int                      NUM_CH    = 4,
    parameter int                      DIV_W     = CFG_W,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV   = {DIV_VDP, DIV_VDP, DIV_PIXEL, DIV_PIXEL},
    parameter logic [NUM_CH*DIV_W-1:0] DEF_PHASE = '0
) (
    input  logic              clk_vdp,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_ack,
    input  logic              resync,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] pending
);

    logic cfg_ack_q, cfg_ack_d;
    logic ch_in_range;

    // Extra bit so NUM_CH == MAX_CH does not wrap the bound to zero
    assign ch_in_range = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

    always_comb begin
        cfg_ack_d = cfg_wr && ch_in_range;
    end

    always_ff @(posedge clk_vdp or posedge reset) begin
        if (reset) begin
            cfg_ack_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_ack_d;
        end
    end

    assign cfg_ack = cfg_ack_q;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
            logic wr_sel;
            assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

            lm80c_ce_chan #(
                .DIV_W     (DIV_W),
                .DEF_DIV   (DEF_DIV[i*DIV_W +: DIV_W]),
                .DEF_PHASE (DEF_PHASE[i*DIV_W +: DIV_W])
            ) u_chan (
                .clk_vdp    (clk_vdp),
                .reset      (reset),
                .wr_i       (wr_sel),
                .wr_div_i   (cfg_div),
                .wr_phase_i (cfg_phase),
                .resync_i   (resync),
                .ce_o       (ce[i]),
                .pending_o  (pending[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lm80c_ce_gen.sv
`default_nettype none
// ============================================================================
// tb_lm80c_ce_gen : scoreboard bench for the CE generator, behavioural model
// Revision 1.0
// ============================================================================
module tb_lm80c_ce_gen;

    logic       clk_vdp = 1'b0;
    logic       reset;
    logic       cfg_wr;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       cfg_ack;
    logic       resync;
    logic [3:0] ce;
    logic [3:0] pending;

    lm80c_ce_gen dut (
        .clk_vdp   (clk_vdp),
        .reset     (reset),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_ack   (cfg_ack),
        .resync    (resync),
        .ce        (ce),
        .pending   (pending)
    );

    always #5 clk_vdp = ~clk_vdp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state: mirrors architectural registers, not RTL structure
    int   m_div[4], m_ph[4], m_sdiv[4], m_sph[4], m_cnt[4];
    logic [3:0] m_pend, m_ce;
    logic       m_ack;
    logic [8:0] exp_q[$];

    int  cyc       = 0;
    bit  gap_mon   = 0;
    int  last_ce1  = -1;

    function automatic int clampv(input int d, input int p);
        return (d != 0 && p >= d) ? d - 1 : p;
    endfunction

    task automatic model_reset();
        int dd[4] = '{2, 2, 4, 4};
        for (int i = 0; i < 4; i++) begin
            m_div[i] = dd[i]; m_sdiv[i] = dd[i];
            m_ph[i]  = 0;     m_sph[i]  = 0;
            m_cnt[i] = 0;
        end
        m_pend = '0; m_ce = '0; m_ack = 1'b0;
    endtask

    task automatic model_step(input bit wr, input int ch, input int dv, input int ph, input bit rs);
        for (int i = 0; i < 4; i++) begin
            bit boundary;
            boundary = (m_div[i] == 0) || (m_cnt[i] == m_div[i] - 1);
            m_ce[i]  = !rs && (m_div[i] != 0) && (m_cnt[i] == m_ph[i]);
            if (wr && ch == i) begin
                m_sdiv[i] = dv; m_sph[i] = ph; m_pend[i] = 1'b1;
            end
            if (rs || (m_pend[i] && boundary)) begin
                if (m_pend[i]) begin
                    m_div[i] = m_sdiv[i];
                    m_ph[i]  = clampv(m_sdiv[i], m_sph[i]);
                    m_pend[i] = 1'b0;
                end
                m_cnt[i] = 0;
            end else if (boundary) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
            end
        end
        m_ack = wr && (ch < 4);
    endtask

    task automatic sample_compare();
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("ce",      32'(ce),      32'(e[3:0]));
        check("pending", 32'(pending), 32'(e[7:4]));
        check("cfg_ack", 32'(cfg_ack), 32'(e[8]));
        if (gap_mon && ce[1]) begin
            if (last_ce1 >= 0) check("ch1_gap_ge4", 32'((cyc - last_ce1) >= 4), 32'd1);
            last_ce1 = cyc;
        end
    endtask

    task automatic step(input bit wr, input int ch, input int dv, input int ph, input bit rs);
        cfg_wr    = wr;
        cfg_ch    = 3'(ch);
        cfg_div   = 8'(dv);
        cfg_phase = 8'(ph);
        resync    = rs;
        model_step(wr, ch, dv, ph, rs);
        exp_q.push_back({m_ack, m_pend, m_ce});
        @(posedge clk_vdp);
        #1;
        cyc++;
        sample_compare();
        @(negedge clk_vdp);
        cfg_wr = 1'b0;
        resync = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        #1;
        model_reset();
        exp_q.delete();
        check("rst_ce",      32'(ce),      32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ack",     32'(cfg_ack), 32'd0);
        for (int k = 0; k < n; k++) @(negedge clk_vdp);
        check("rst_ce_hold", 32'(ce), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; cfg_wr = 0; cfg_ch = 0; cfg_div = 0; cfg_phase = 0; resync = 0;
        @(negedge clk_vdp);
        apply_reset(3);

        // Defaults: ch0/ch1 every 2nd cycle, ch2/ch3 every 4th
        idle(12);

        // Give ch1 a period of 4, then reprogram mid-period to div=5 phase=2
        step(1, 1, 4, 0, 0);
        guard = 0;
        while (!(m_div[1] == 4 && m_cnt[1] == 1) && guard < 20) begin
            step(0, 0, 0, 0, 0);
            guard++;
        end
        check("ch1_reach_cnt1", 32'(guard < 20), 32'd1);
        gap_mon = 1; last_ce1 = -1;
        step(1, 1, 5, 2, 0);
        idle(22);
        gap_mon = 0;

        // Phase clamp: div=3 phase=7 on ch2, then a double write while pending
        step(1, 2, 3, 7, 0);
        idle(12);
        step(1, 2, 6, 1, 0);
        step(1, 2, 2, 1, 0);
        idle(10);

        // ch0 off, then divide-by-1
        step(1, 0, 0, 0, 0);
        idle(8);
        step(1, 0, 1, 0, 0);
        idle(8);

        // Write coinciding with resync, then out-of-range channel
        idle(3);
        step(1, 3, 6, 0, 1);
        idle(14);
        step(1, 5, 9, 0, 0);
        idle(3);

        // Resync with no write, phase offset on ch3
        step(1, 3, 6, 3, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        idle(10);

        // Reset while ch1 has a pending write
        step(1, 1, 7, 0, 0);
        idle(1);
        check("pend1_before_rst", 32'(pending[1] === m_pend[1] && m_pend[1]), 32'd1);
        apply_reset(2);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/lm80c_ce_gen.md
LM80C_CE_GEN -- requirements
Module: lm80c_ce_gen

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4: number of independent clock-enable channels, range 1..8.
REQ-002 The module SHALL have parameter DIV_W, default 8: width of the divisor and phase fields.
REQ-003 The module SHALL have parameter DEF_DIV, default {8'd4,8'd4,8'd2,8'd2}: packed reset divisors, channel 0 in the LSBs.
REQ-004 The module SHALL have parameter DEF_PHASE, default all zero: packed reset phases, channel 0 in the LSBs.
REQ-005 The module SHALL have port clk_vdp, input, 1: clock (10.738636 MHz domain).
REQ-006 The module SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 The module SHALL have port cfg_wr, input, 1: one-cycle configuration write strobe.
REQ-008 The module SHALL have port cfg_ch, input, 3: target channel of the write.
REQ-009 The module SHALL have port cfg_div, input, DIV_W: new divisor (0 = channel off).
REQ-010 The module SHALL have port cfg_phase, input, DIV_W: new phase offset.
REQ-011 The module SHALL have port cfg_ack, output, 1: write accepted, one-cycle pulse.
REQ-012 The module SHALL have port resync, input, 1: realign all channels.
REQ-013 The module SHALL have port ce, output, NUM_CH: one-cycle enable pulses.
REQ-014 The module SHALL have port pending, output, NUM_CH: shadow configuration not yet applied.

Function
REQ-015 Each channel SHALL hold an active divisor/phase pair, a shadow divisor/phase pair and a DIV_W-bit counter cnt.
REQ-016 When the active divisor D is nonzero, cnt SHALL count 0..D-1 and wrap to 0.
REQ-017 ce[i] SHALL be registered and high for exactly the one cycle following each cycle in which cnt==phase and D!=0.
REQ-018 If the active divisor is 1, ce[i] SHALL be high every cycle.
REQ-019 If the active divisor is 0, ce[i] SHALL be 0 and cnt SHALL be held at 0.
REQ-020 A phase value >= its divisor SHALL be clamped to divisor-1 when it is loaded into the active pair.
REQ-021 A cfg_wr with cfg_ch<NUM_CH SHALL write the shadow pair, set pending[cfg_ch], and pulse cfg_ack on the following cycle.
REQ-022 A cfg_wr with cfg_ch>=NUM_CH SHALL be ignored, with no cfg_ack pulse.
REQ-023 A pending shadow pair SHALL be loaded into the active pair, with cnt set to 0 and pending cleared, on the cycle in which cnt==D-1 (the wrap point), so that no period is truncated or produces a runt pulse.
REQ-024 If the active divisor is 0, a pending shadow pair SHALL load on the cycle after the write.
REQ-025 A second cfg_wr to the same channel while pending is set SHALL overwrite the shadow pair; only the last value is applied.
REQ-026 resync SHALL set all counters to 0 on the next edge, load every pending shadow pair immediately and clear all pending bits.
REQ-027 No ce pulse SHALL be emitted in the resync cycle unless the new cnt (0) matches phase on the following cycle.
REQ-028 When cfg_wr and resync occur in the same cycle, the written value SHALL be applied by that resync.
REQ-029 When cfg_wr coincides with the wrap cycle of the same channel, the new value SHALL be applied at that wrap.
REQ-030 Channels SHALL be fully independent, except through resync.

Reset
REQ-031 On reset: active and shadow pairs = DEF_DIV/DEF_PHASE; cnt=0; ce=0; pending=0; cfg_ack=0.
REQ-032 Reset asserted mid-period or with a pending write SHALL discard all shadow state.
REQ-033 After reset release, channel counting SHALL start on the first clk_vdp edge.

Structure
REQ-034 Package lm80c_ce_pkg SHALL hold MAX_CH=8, CH_W=3, the default divisor constants (pixel=2, vdp=4) and the channel config struct (div, phase).
REQ-035 One sub-module, lm80c_ce_chan (counter, active/shadow pair, wrap-load, ce register), SHALL be instantiated NUM_CH times.
REQ-036 The top level SHALL contain only write decode, cfg_ack and resync fan-out.

Verification
REQ-037 After reset with defaults, ch0 SHALL pulse every 2nd cycle and ch2 every 4th cycle, with ce=0 during reset.
REQ-038 Writing ch1 div=5, phase=2 while cnt=1 of a D=4 period SHALL hold pending until the wrap; ch1 then pulses at cnt==2 every 5 cycles, and no period is shorter than 4.
REQ-039 Writing div=3, phase=7 SHALL clamp phase to 2 and produce a pulse every 3 cycles.
REQ-040 Writing div=0 then div=1 SHALL give ce low for the whole off period, then ce high continuously starting two cycles after the second write.
REQ-041 cfg_wr to ch3 (div=6) in the same cycle as resync SHALL align all counters to 0 with ch3 at period 6 at once; a write to cfg_ch=5 with NUM_CH=4 SHALL produce no cfg_ack.
REQ-042 Reset asserted while pending[1]=1 SHALL restore DEF_DIV for ch1 and leave pending=0.
